// File: rtl/scan_frame_sched_if.sv
// Requester/scan-side signal bundle for scan_frame_sched.
// slave is the scheduler's view; master is the requesting agents' view.
interface scan_frame_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    grant;
  logic [5:0]         count;
  logic               trst;
  logic               dq_en;
  logic               sr_en;
  logic               tclk;
  logic               sdo;
  logic               busy;
  logic [NREQ-1:0]    done;

  modport master (
    output req, wdata,
    input  grant, count, trst, dq_en, sr_en, tclk, sdo, busy, done
  );

  modport slave (
    input  req, wdata,
    output grant, count, trst, dq_en, sr_en, tclk, sdo, busy, done
  );
endinterface

// File: rtl/scan_frame_sched.sv
// Round-robin scheduler sharing one serial scan frame between NREQ requesters.
// Optional macro SCAN_PARITY_EN appends an odd-parity bit after the data word.
module scan_frame_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned FRAME_LEN = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  scan_frame_sched_if.slave sif
);

  localparam int unsigned CW  = 6;
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW1 = PW + 1;
`ifdef SCAN_PARITY_EN
  localparam int unsigned SHIFT_END = DW + 2;
`else
  localparam int unsigned SHIFT_END = DW + 1;
`endif
  localparam int unsigned DONE_AT = SHIFT_END + 1;
  localparam int unsigned LAST    = FRAME_LEN - 1;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t          state;
  state_t          nxt_state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   nxt_count;
  logic            arb;
  logic            in_frame;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [PW1-1:0]  sum;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic [DW-1:0]   shreg;
  logic [DW-1:0]   word_sel;
  logic [DW-1:0]   words [NREQ];
  logic            trst;
  logic            dq_en;
  logic            sr_en;
  logic            tclk;
  logic            sdo;
  logic            busy;
`ifdef SCAN_PARITY_EN
  logic            par;
`endif

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_words
    assign words[g] = sif.wdata[g*DW +: DW];
  end

  assign word_sel = words[gidx];

  // Round-robin search starting one past the last winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      sum = PW1'(ptr) + PW1'(i);
      if (sum >= PW1'(NREQ)) sum = sum - PW1'(NREQ);
      if (!pick_valid && sif.req[PW'(sum)]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(sum);
      end
    end
  end

  // Next state / frame position; arb marks an edge that latches a new grant.
  always_comb begin
    nxt_state = state;
    nxt_count = count;
    arb       = 1'b0;
    case (state)
      IDLE: begin
        nxt_count = '0;
        if (pick_valid) begin
          nxt_state = FRAME;
          arb       = 1'b1;
        end
      end
      FRAME: begin
        if (count == CW'(LAST)) begin
          nxt_count = '0;
          if (pick_valid) arb = 1'b1;
          else            nxt_state = IDLE;
        end else begin
          nxt_count = count + CW'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_count = '0;
      end
    endcase
  end

  assign in_frame = (nxt_state == FRAME);

  // Outputs are decoded from the upcoming count so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      ptr   <= PW'(NREQ - 1);
      gidx  <= '0;
      grant <= '0;
      done  <= '0;
      shreg <= '0;
      trst  <= 1'b0;
      dq_en <= 1'b0;
      sr_en <= 1'b0;
      tclk  <= 1'b0;
      sdo   <= 1'b0;
      busy  <= 1'b0;
`ifdef SCAN_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      count <= nxt_count;
      busy  <= in_frame;
      if (arb) begin
        grant <= NREQ'(1) << pick_idx;
        gidx  <= pick_idx;
        ptr   <= pick_idx;
      end else if (!in_frame) begin
        grant <= '0;
      end
      trst  <= in_frame && (nxt_count == CW'(0));
      dq_en <= in_frame && (nxt_count == CW'(1));
      sr_en <= in_frame && (nxt_count >= CW'(2)) && (nxt_count <= CW'(SHIFT_END));
      tclk  <= sr_en;
      done  <= (in_frame && (nxt_count == CW'(DONE_AT))) ? grant : '0;
      if (in_frame && (nxt_count == CW'(1))) begin
        shreg <= word_sel;
`ifdef SCAN_PARITY_EN
        par   <= ~^word_sel;
`endif
      end
      if (in_frame && (nxt_count >= CW'(2)) && (nxt_count <= CW'(DW + 1))) begin
        sdo   <= shreg[DW-1];
        shreg <= shreg << 1;
`ifdef SCAN_PARITY_EN
      end else if (in_frame && (nxt_count == CW'(DW + 2))) begin
        sdo   <= par;
`endif
      end else begin
        sdo   <= 1'b0;
      end
    end
  end

  assign sif.grant = grant;
  assign sif.count = count;
  assign sif.trst  = trst;
  assign sif.dq_en = dq_en;
  assign sif.sr_en = sr_en;
  assign sif.tclk  = tclk;
  assign sif.sdo   = sdo;
  assign sif.busy  = busy;
  assign sif.done  = done;

endmodule

// File: tb/tb_scan_frame_sched.sv
// Directed bench for scan_frame_sched: reset, single frame, rotation, reset abort, req drop.
// Honours SCAN_PARITY_EN the same way as the design.
module tb_scan_frame_sched;

  localparam int DW = 32;
`ifdef SCAN_PARITY_EN
  localparam int SE = DW + 2;
`else
  localparam int SE = DW + 1;
`endif
  localparam int DA = SE + 1;

  logic clk;
  logic rst_n;
  logic [31:0] wd [4];
  int total;
  int bad;

  scan_frame_sched_if #(.NREQ(4), .DW(32)) ifc ();

  scan_frame_sched #(.NREQ(4), .DW(32), .FRAME_LEN(40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_wdata();
    ifc.wdata = {wd[3], wd[2], wd[1], wd[0]};
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".grant"}, 32'(ifc.grant), 32'(0));
    chk({tag, ".count"}, 32'(ifc.count), 32'(0));
    chk({tag, ".busy"},  32'(ifc.busy),  32'(0));
    chk({tag, ".trst"},  32'(ifc.trst),  32'(0));
    chk({tag, ".dq_en"}, 32'(ifc.dq_en), 32'(0));
    chk({tag, ".sr_en"}, 32'(ifc.sr_en), 32'(0));
    chk({tag, ".tclk"},  32'(ifc.tclk),  32'(0));
    chk({tag, ".sdo"},   32'(ifc.sdo),   32'(0));
    chk({tag, ".done"},  32'(ifc.done),  32'(0));
  endtask

  // Entered while count 0 of a frame is visible; leaves count 39 visible.
  task automatic check_frame(input string tag, input logic [3:0] g, input logic [31:0] w,
                             input int drop_at, input logic [3:0] drop_val);
    logic [31:0] tmp;
    logic        e_sdo;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick();
      tmp   = w << (c - 2);
      e_sdo = 1'b0;
      if (c >= 2 && c <= DW + 1) e_sdo = tmp[31];
`ifdef SCAN_PARITY_EN
      if (c == DW + 2) e_sdo = ~^w;
`endif
      chk({tag, ".count"}, 32'(ifc.count), 32'(c));
      chk({tag, ".grant"}, 32'(ifc.grant), 32'(g));
      chk({tag, ".busy"},  32'(ifc.busy),  32'(1));
      chk({tag, ".trst"},  32'(ifc.trst),  32'(c == 0));
      chk({tag, ".dq_en"}, 32'(ifc.dq_en), 32'(c == 1));
      chk({tag, ".sr_en"}, 32'(ifc.sr_en), 32'(c >= 2 && c <= SE));
      chk({tag, ".tclk"},  32'(ifc.tclk),  32'(c >= 3 && c <= SE + 1));
      chk({tag, ".sdo"},   32'(ifc.sdo),   32'(e_sdo));
      chk({tag, ".done"},  32'(ifc.done),  (c == DA) ? 32'(g) : 32'(0));
      if (c == drop_at) ifc.req = drop_val;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    wd[0] = 32'hA5A5_0F0F;
    wd[1] = 32'h1234_5678;
    wd[2] = 32'hC3E1_8001;
    wd[3] = 32'h8000_00FF;
    rst_n   = 1'b0;
    ifc.req = 4'b0000;
    pack_wdata();

    // Reset and idle hold
    tick();
    tick();
    chk_quiet("reset");
    rst_n = 1'b1;
    repeat (50) tick();
    chk_quiet("idle50");

    // Single request from requester 0
    ifc.req = 4'b0001;
    tick();
    check_frame("single", 4'b0001, wd[0], DA, 4'b0000);
    tick();
    chk_quiet("single_end");

    // All request: rotation from a fresh pointer, back-to-back frames
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    ifc.req = 4'b1111;
    tick();
    check_frame("rr0", 4'b0001, wd[0], -1, 4'b0000);
    tick();
    check_frame("rr1", 4'b0010, wd[1], -1, 4'b0000);
    tick();
    check_frame("rr2", 4'b0100, wd[2], -1, 4'b0000);
    tick();
    check_frame("rr3", 4'b1000, wd[3], -1, 4'b0000);
    tick();
    check_frame("rr4", 4'b0001, wd[0], DA, 4'b0000);
    tick();
    chk_quiet("rr_end");

    // Reset asserted at count 15 aborts the frame
    ifc.req = 4'b0010;
    tick();
    chk("abort.grant", 32'(ifc.grant), 32'(4'b0010));
    repeat (15) tick();
    chk("abort.count15", 32'(ifc.count), 32'(15));
    rst_n = 1'b0;
    #1;
    chk_quiet("abort_now");
    tick();
    tick();
    chk_quiet("abort_hold");
    ifc.req = 4'b0100;
    rst_n   = 1'b1;
    tick();
    check_frame("post_rst", 4'b0100, wd[2], DA, 4'b0000);
    tick();
    chk_quiet("post_rst_end");

    // Requester 1 drops req at count 5; frame still completes
    ifc.req = 4'b0010;
    tick();
    check_frame("drop", 4'b0010, wd[1], 5, 4'b0000);
    tick();
    chk_quiet("drop_end");

    // Single-bit word: parity 0 when enabled, last data bit 1 otherwise
    wd[0] = 32'h0000_0001;
    pack_wdata();
    ifc.req = 4'b0001;
    tick();
    check_frame("par", 4'b0001, wd[0], DA, 4'b0000);
    tick();
    chk_quiet("par_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_frame_sched.md
# scan_frame_sched

Frame scheduler for the scan/test interface. Shares one 40-cycle serial scan frame between NREQ requesters using round-robin arbitration. Drives the frame counter and the tclk/trst/dq_en/sr_en control strobes, and shifts the winner's word out serially. Sits between the requesting test agents and the scan interface FSM/shift register.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- DW, 32: data word width shifted per frame (≤ FRAME_LEN-8).
- FRAME_LEN, 40: cycles per frame; counter width is 6 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; level, held until its done
- wdata  in  NREQ*DW  per-requester data word; requester i occupies bits [i*DW +: DW]
- grant  out  NREQ  one-hot grant, held for the whole frame
- count  out  6  frame position 0..FRAME_LEN-1
- trst  out  1  scan reset strobe
- dq_en  out  1  parallel-load strobe
- sr_en  out  1  shift-enable strobe
- tclk  out  1  scan sample clock strobe
- sdo  out  1  serial data out, MSB first
- busy  out  1  frame in progress
- done  out  NREQ  one-cycle completion pulse to the granted requester

## Operation
- States: IDLE, FRAME.
- IDLE:
  - count=0; all strobes low.
  - Any req bit set → round-robin pick → latch grant, enter FRAME with count=0 on the next edge.
- Round-robin:
  - Search starts at (last winner+1) mod NREQ. After reset the pointer is NREQ-1, so requester 0 has top priority first.
- FRAME, count increments each cycle:
  - count 0: trst=1.
  - count 1: dq_en=1; shift register ← wdata of the granted requester.
  - counts 2..DW+1: sr_en=1; sdo = shreg MSB; shreg shifts left, zero fill.
  - count DW+2: done[granted]=1.
  - Remaining counts: gap, strobes low, sdo=0.
- At count FRAME_LEN-1:
  - count→0.
  - If any req is set, excluding the current winner's req bit this cycle, or the current winner re-requests: re-arbitrate, update grant, stay in FRAME (back-to-back frames, no idle cycle).
  - Otherwise grant←0 and go to IDLE.
- A requester dropping req mid-frame does not abort the frame. Its data is already sampled at count 1.
- New req bits arriving mid-frame wait for the frame boundary.
- busy = (state==FRAME).

## Timing
- Reset values:
  - State IDLE, count=0, grant=0, pointer=NREQ-1.
  - trst=dq_en=sr_en=tclk=sdo=busy=0; done=0.
- All outputs are registered.
- Strobes are decoded from count and are valid in the same cycle count shows that value.
- tclk is sr_en delayed by one cycle: high for counts 3..DW+2. The consumer samples sdo on tclk.
- Latency from req rising in IDLE:
  - grant and busy high after 1 clk; trst in that same cycle.
  - First sdo bit after 3 clk.
  - done after DW+3 clk.
- rst_n assertion mid-frame:
  - Immediately clears all outputs and the frame. No done is issued.
  - After release, arbitration restarts with requester 0 priority.
- Simultaneous req from all requesters:
  - Each is served once per NREQ frames.

## Configuration
- SCAN_PARITY_EN defined:
  - The odd-parity bit of the loaded word is shifted at count DW+2; sr_en is high for counts 2..DW+2.
  - tclk covers counts 3..DW+3; done moves to count DW+3.
  - Requires DW ≤ FRAME_LEN-9.
- Undefined: no parity bit; timing exactly as above.

## Test plan
- Reset with req=0 → count=0, all outputs 0; hold 50 cycles → still IDLE.
- req=4'b0001, wdata[31:0]=32'hA5A5_0F0F:
  - grant=0001 and trst at count 0; dq_en at count 1.
  - sdo bits 1,0,1,0,0,1,0,1… at counts 2..33; tclk at counts 3..34.
  - done[0] at count 34; back to IDLE after count 39.
- req=4'b1111 held → grants rotate 0001, 0010, 0100, 1000, 0001 on consecutive frames, with no idle cycle between frames.
- rst_n pulsed low at count 15 of a frame → outputs 0 immediately, no done; after release with req=4'b0100 → grant=0100.
- req[1] dropped at count 5 → frame completes, done[1] at count 34.
- SCAN_PARITY_EN, wdata=32'h0000_0001 → parity bit 0 at count 34, done at count 35.
